// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO: pointer width derivation and Gray coding.
package fifo_pkg;

  // Working width for the width-generic Gray helpers; callers cast in and out.
  localparam int unsigned GRAY_CALC_W = 32;

  // Memory address width for a power-of-two depth.
  function automatic int unsigned addr_w_of(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Pointer width: address width plus one wrap bit.
  function automatic int unsigned ptr_w_of(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Binary to reflected Gray code.
  function automatic logic [GRAY_CALC_W-1:0] bin2gray(input logic [GRAY_CALC_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/fifo_wptr_full_gray2bin.sv
// Gray to binary converter; mirror of the bin2gray helper.
module fifo_wptr_full_gray2bin #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  // Each binary bit is the XOR of all Gray bits at or above its position.
  always_comb begin
    bin_o = '0;
    for (int i = 0; i < W; i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer, full / almost-full / level / sticky-overflow logic
// for the asynchronous FIFO.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ADDR_W   = addr_w_of(DEPTH),
  parameter int unsigned PTR_W    = ADDR_W + 1,
  parameter int unsigned AFULL_TH = DEPTH - 2
) (
  input  logic              WCLK,
  input  logic              WRST,
  input  logic              WINC,
  input  logic [PTR_W-1:0]  WQ2_RPTR,
  input  logic              OVF_CLR,
  output logic              WFULL,
  output logic              WAFULL,
  output logic [PTR_W-1:0]  WPTR,
  output logic [ADDR_W-1:0] WADDR,
  output logic [PTR_W-1:0]  WLEVEL,
  output logic              WOVF
);

  logic [PTR_W-1:0] wbin_q,   wbin_d;
  logic [PTR_W-1:0] wptr_q,   wptr_d;
  logic [PTR_W-1:0] wlevel_q, wlevel_d;
  logic             wfull_q,  wfull_d;
  logic             wafull_q, wafull_d;
  logic             wovf_q,   wovf_d;

  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] rptr_full_cmp;
  logic             wr_ok;

  // Synchronized read pointer back to binary for level arithmetic.
  fifo_wptr_full_gray2bin #(
    .W (PTR_W)
  ) u_gray2bin (
    .gray_i (WQ2_RPTR),
    .bin_o  (rbin)
  );

  // Full when the next write pointer equals the read pointer with the top two Gray bits inverted.
  assign rptr_full_cmp = {~WQ2_RPTR[PTR_W-1:PTR_W-2], WQ2_RPTR[PTR_W-3:0]};

  assign wr_ok = WINC & ~wfull_q;

  // Next pointer, flags, level and sticky overflow.
  always_comb begin
    wbin_d   = wbin_q;
    wptr_d   = wptr_q;
    wlevel_d = wlevel_q;
    wfull_d  = wfull_q;
    wafull_d = wafull_q;
    wovf_d   = wovf_q;

    wbin_d   = wbin_q + PTR_W'(wr_ok);
    wptr_d   = PTR_W'(bin2gray(GRAY_CALC_W'(wbin_d)));
    wfull_d  = (wptr_d == rptr_full_cmp);
    wlevel_d = wbin_d - rbin;
    wafull_d = (32'(wlevel_d) >= AFULL_TH);
    // A dropped write sets the flag; set beats a simultaneous clear.
    wovf_d   = (WINC & wfull_q) | (wovf_q & ~OVF_CLR);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge WCLK or posedge WRST) begin
    if (WRST) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
    end
  end

  assign WFULL  = wfull_q;
  assign WAFULL = wafull_q;
  assign WPTR   = wptr_q;
  assign WADDR  = wbin_q[ADDR_W-1:0];
  assign WLEVEL = wlevel_q;
  assign WOVF   = wovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full: directed scenarios plus randomized traffic
// checked every cycle against a count-based model of the FIFO.
module tb_fifo_wptr_full;

  localparam int unsigned DEPTH    = 16;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned PTR_W    = 5;
  localparam int unsigned AFULL_TH = 14;
  localparam int unsigned MODV     = 32;

  logic              WCLK = 1'b0;
  logic              WRST;
  logic              WINC;
  logic [PTR_W-1:0]  WQ2_RPTR;
  logic              OVF_CLR;
  logic              WFULL;
  logic              WAFULL;
  logic [PTR_W-1:0]  WPTR;
  logic [ADDR_W-1:0] WADDR;
  logic [PTR_W-1:0]  WLEVEL;
  logic              WOVF;

  int total = 0;
  int bad   = 0;

  // Model: counts of words written / read (mod 32) and the derived flags.
  int unsigned m_w = 0;
  int unsigned m_r = 0;
  int unsigned m_lvl = 0;
  bit          m_full = 0;
  bit          m_afull = 0;
  bit          m_ovf = 0;
  bit          cmp_en = 0;

  fifo_wptr_full #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .PTR_W    (PTR_W),
    .AFULL_TH (AFULL_TH)
  ) dut (
    .WCLK     (WCLK),
    .WRST     (WRST),
    .WINC     (WINC),
    .WQ2_RPTR (WQ2_RPTR),
    .OVF_CLR  (OVF_CLR),
    .WFULL    (WFULL),
    .WAFULL   (WAFULL),
    .WPTR     (WPTR),
    .WADDR    (WADDR),
    .WLEVEL   (WLEVEL),
    .WOVF     (WOVF)
  );

  always #5 WCLK = ~WCLK;

  function automatic logic [PTR_W-1:0] gray_of(input int unsigned b);
    logic [PTR_W-1:0] x;
    x = PTR_W'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one write-clock edge using the inputs sampled there.
  task automatic model_edge();
    bit acc;
    acc = WINC && !m_full;
    m_ovf = (WINC && m_full) || (m_ovf && !OVF_CLR);
    if (acc) m_w = (m_w + 1) % MODV;
    m_lvl   = (m_w + MODV - m_r) % MODV;
    m_full  = (m_lvl == DEPTH);
    m_afull = (m_lvl >= AFULL_TH);
  endtask

  // Apply inputs, take one edge, update the model, leave inputs settled.
  task automatic cyc(input bit winc, input bit clr, input int unsigned r);
    WINC     = winc;
    OVF_CLR  = clr;
    m_r      = r % MODV;
    WQ2_RPTR = gray_of(m_r);
    @(posedge WCLK);
    model_edge();
    #1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge WCLK) begin
    if (cmp_en && !WRST) begin
      chk("full",  32'(WFULL),  32'(m_full));
      chk("afull", 32'(WAFULL), 32'(m_afull));
      chk("wptr",  32'(WPTR),   32'(gray_of(m_w)));
      chk("waddr", 32'(WADDR),  m_w % DEPTH);
      chk("level", 32'(WLEVEL), m_lvl);
      chk("ovf",   32'(WOVF),   32'(m_ovf));
    end
  end

  initial begin
    logic [PTR_W-1:0] prev_ptr;
    bit seen_wrap;
    WRST = 1'b1; WINC = 1'b0; OVF_CLR = 1'b0; WQ2_RPTR = '0;
    #12;
    chk("rst_full", 32'(WFULL), 0);
    chk("rst_wptr", 32'(WPTR), 0);
    chk("rst_ovf", 32'(WOVF), 0);
    @(negedge WCLK);
    WRST = 1'b0;
    cmp_en = 1;
    #1;

    // Fill from empty.
    for (int i = 0; i < 16; i++) begin
      chk("fill_addr", 32'(WADDR), i);
      cyc(1, 0, 0);
      if (i == 12) chk("afull_before_14", 32'(WAFULL), 0);
      if (i == 13) chk("afull_at_14", 32'(WAFULL), 1);
    end
    chk("fill_full", 32'(WFULL), 1);
    chk("fill_wptr", 32'(WPTR), 32'h18);
    chk("fill_level", 32'(WLEVEL), 16);
    chk("fill_afull", 32'(WAFULL), 1);

    // Overflow and clear.
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("ovf_wptr_hold", 32'(WPTR), 32'h18);
    chk("ovf_set", 32'(WOVF), 1);
    cyc(0, 1, 0);
    chk("ovf_clear", 32'(WOVF), 0);
    cyc(1, 1, 0);
    chk("ovf_set_wins", 32'(WOVF), 1);
    cyc(0, 1, 0);
    chk("ovf_clear2", 32'(WOVF), 0);

    // Drain visibility: read pointer Gray 00110 = binary 4.
    cyc(0, 0, 4);
    chk("drain_rptr_gray", 32'(WQ2_RPTR), 32'h06);
    chk("drain_full", 32'(WFULL), 0);
    chk("drain_level", 32'(WLEVEL), 12);
    chk("drain_afull", 32'(WAFULL), 0);

    // Threshold edge: 13 -> 14 -> read brings it back to 13.
    cyc(1, 0, 4);
    chk("th_level13", 32'(WLEVEL), 13);
    chk("th_afull13", 32'(WAFULL), 0);
    cyc(1, 0, 4);
    chk("th_level14", 32'(WLEVEL), 14);
    chk("th_afull14", 32'(WAFULL), 1);
    cyc(0, 0, 5);
    chk("th_afull_drop", 32'(WAFULL), 0);
    chk("th_level_drop", 32'(WLEVEL), 13);

    // Wrap with the reader two entries behind.
    cyc(0, 0, m_w + MODV - 2);
    seen_wrap = 0;
    for (int i = 0; i < 40; i++) begin
      prev_ptr = WPTR;
      cyc(1, 0, m_w + MODV - 1);
      chk("wrap_level", 32'(WLEVEL), 2);
      chk("wrap_full", 32'(WFULL), 0);
      if (prev_ptr == 5'b10000 && WPTR == 5'b00000) seen_wrap = 1;
    end
    chk("wrap_seen", 32'(seen_wrap), 1);

    // Async reset mid-stream at level 9.
    for (int i = 0; i < 7; i++) cyc(1, 0, m_r);
    chk("pre_rst_level", 32'(WLEVEL), 9);
    WINC = 1'b0;
    #1;
    WRST = 1'b1;
    #1;
    chk("arst_full", 32'(WFULL), 0);
    chk("arst_afull", 32'(WAFULL), 0);
    chk("arst_wptr", 32'(WPTR), 0);
    chk("arst_waddr", 32'(WADDR), 0);
    chk("arst_level", 32'(WLEVEL), 0);
    chk("arst_ovf", 32'(WOVF), 0);
    m_w = 0; m_r = 0; m_lvl = 0; m_full = 0; m_afull = 0; m_ovf = 0;
    WQ2_RPTR = '0;
    #1;
    WRST = 1'b0;
    #1;
    chk("post_rst_addr", 32'(WADDR), 0);
    cyc(1, 0, 0);
    chk("post_rst_addr1", 32'(WADDR), 1);
    chk("post_rst_level", 32'(WLEVEL), 1);

    // Randomized traffic; read rate alternates to visit both full and empty.
    for (int i = 0; i < 3000; i++) begin
      int unsigned step;
      int unsigned lvl_now;
      bit w;
      bit c;
      w = ($urandom % 4) != 0;
      c = ($urandom % 8) == 0;
      lvl_now = (m_w + MODV - m_r) % MODV;
      if (((i / 200) % 2) == 0) step = (($urandom % 4) == 0) ? 1 : 0;
      else step = $urandom % 3;
      if (step > lvl_now) step = lvl_now;
      cyc(w, c, m_r + step);
    end

    cmp_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
